// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter, 8E1 frames, one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       busy,
    output logic       tx_done
);

    localparam int              CW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    idx_q,    idx_d;
    logic [7:0]    shift_q,  shift_d;
    logic          parity_q, parity_d;
    logic [7:0]    hold_q,   hold_d;
    logic          full_q,   full_d;
    logic          txd_q,    txd_d;
    logic          done_q,   done_d;

    logic w_accept;
    logic w_bit_end;

    assign w_accept  = tx_valid && !full_q;
    assign w_bit_end = (cnt_q == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            hold_q   <= '0;
            full_q   <= 1'b0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
        end
    end

    // Accept and load are mutually exclusive: accept needs an empty holder, load a full one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        hold_d   = hold_q;
        full_d   = full_q;

        if (w_accept) begin
            hold_d = TxData;
            full_d = 1'b1;
        end

        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (full_q) begin
                    shift_d  = hold_q;
                    parity_d = ^hold_q;
                    full_d   = 1'b0;
                    state_d  = c_START;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = c_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = c_PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_PARITY: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    state_d = c_STOP;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (full_q) begin
                        shift_d  = hold_q;
                        parity_d = ^hold_q;
                        full_d   = 1'b0;
                        state_d  = c_START;
                    end else begin
                        state_d = c_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = c_IDLE;
            end
        endcase
    end

    // Line value is computed from the next state so TxD comes straight off a flop.
    always_comb begin
        txd_d  = 1'b1;
        done_d = (state_q == c_STOP) && w_bit_end;
        case (state_d)
            c_START:  txd_d = 1'b0;
            c_DATA:   txd_d = shift_d[idx_d];
            c_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
    end

    assign TxD      = txd_q;
    assign tx_done  = done_q;
    assign busy     = (state_q != c_IDLE);
    assign tx_ready = !full_q;

endmodule
`default_nettype wire
